// File: rtl/spi_master.sv
// SPI master, mode 0 (SCK idles low, data sampled on rising SCK, changed on
// falling SCK). One frame of WIDTH bits, MSB first, framed by an active-low
// slave select with DIV-cycle setup, hold and inter-frame gap phases.
module spi_master #(
   parameter int WIDTH = 32,
   parameter int DIV   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic             ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             done,
   output logic             sck,
   output logic             ssel,
   output logic             mosi,
   input  logic             miso
);

   localparam int BW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         phase_q, phase_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic [WIDTH-1:0]   tx_q, tx_d;
   logic [WIDTH-1:0]   rx_q, rx_d;
   logic [WIDTH-1:0]   rx_data_q, rx_data_d;
   logic               done_q, done_d;
   logic               sck_q, sck_d;
   logic               ssel_q, ssel_d;

   logic               phase_last;
   logic               last_bit;

   assign phase_last = (phase_q == 8'(DIV - 1));
   assign last_bit   = (bit_q == BW'(WIDTH - 1));

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         phase_q   <= 8'd0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         done_q    <= 1'b0;
         sck_q     <= 1'b0;
         ssel_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
         sck_q     <= sck_d;
         ssel_q    <= ssel_d;
      end
   end

   // Next-state logic: each non-idle phase lasts DIV cycles of the phase counter.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q + 8'd1;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      sck_d     = sck_q;
      ssel_d    = ssel_q;

      case (state_q)
         IDLE: begin
            phase_d = 8'd0;
            if (start) begin
               tx_d    = tx_data;
               bit_d   = '0;
               ssel_d  = 1'b0;
               // The accept cycle is counted as the first setup cycle so that
               // back-to-back frames repeat every 2*DIV*(WIDTH+1) cycles.
               phase_d = 8'd1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (phase_last) begin
               phase_d = 8'd0;
               sck_d   = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (phase_last) begin
               phase_d = 8'd0;
               sck_d   = 1'b0;
               rx_d    = {rx_q[WIDTH-2:0], miso};
               bit_d   = bit_q + 1'b1;
               if (last_bit) begin
                  state_d = HOLD;
               end else begin
                  tx_d    = {tx_q[WIDTH-2:0], 1'b0};
                  state_d = LOW;
               end
            end
         end
         LOW: begin
            if (phase_last) begin
               phase_d = 8'd0;
               sck_d   = 1'b1;
               state_d = HIGH;
            end
         end
         HOLD: begin
            if (phase_last) begin
               phase_d   = 8'd0;
               ssel_d    = 1'b1;
               rx_data_d = rx_q;
               done_d    = 1'b1;
               state_d   = GAP;
            end
         end
         GAP: begin
            if (phase_last) begin
               phase_d = 8'd0;
               state_d = IDLE;
            end
         end
         default: begin
            phase_d = 8'd0;
            state_d = IDLE;
         end
      endcase
   end

   assign ready   = (state_q == IDLE);
   assign rx_data = rx_data_q;
   assign done    = done_q;
   assign sck     = sck_q;
   assign ssel    = ssel_q;
   // MOSI is only driven while the slave is selected for the data phases.
   assign mosi    = tx_q[WIDTH-1] &
                    ((state_q == SETUP) || (state_q == HIGH) ||
                     (state_q == LOW)   || (state_q == HOLD));

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a 32-bit/DIV=8 instance and an 8-bit/DIV=4 instance.
// The reference expectations come from frame-level arithmetic: the received
// word equals the word presented on MISO MSB first, and completion falls at
// 2*DIV*WIDTH+DIV cycles after the accept cycle.
module tb_spi_master;

   localparam int W  = 32;
   localparam int D  = 8;
   localparam int N  = 2 * D * W + D;   // done cycle, 520
   localparam int P  = N + D;           // frame period, 528
   localparam int W2 = 8;
   localparam int D2 = 4;
   localparam int N2 = 2 * D2 * W2 + D2; // 68

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  tx_data = '0;
   logic          ready, done, sck, ssel, mosi, miso;
   logic [W-1:0]  rx_data;

   logic          start2 = 1'b0;
   logic [W2-1:0] tx2 = '0;
   logic          ready2, done2, sck2, ssel2, mosi2;
   logic [W2-1:0] rx2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_master #(.WIDTH(W), .DIV(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
      .ready(ready), .rx_data(rx_data), .done(done), .sck(sck),
      .ssel(ssel), .mosi(mosi), .miso(miso)
   );

   spi_master #(.WIDTH(W2), .DIV(D2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx2),
      .ready(ready2), .rx_data(rx2), .done(done2), .sck(sck2),
      .ssel(ssel2), .mosi(mosi2), .miso(mosi2)
   );

   // Bus monitors: edge counts and the MOSI word as seen by a mode-0 slave.
   int           rise_cnt = 0;
   int           fall_cnt = 0;
   logic [W-1:0] mosi_sh = '0;
   int           r2_cnt = 0;
   logic [W2-1:0] m2_sh = '0;

   always @(posedge sck) if (!ssel) begin
      rise_cnt <= rise_cnt + 1;
      mosi_sh  <= {mosi_sh[W-2:0], mosi};
   end

   always @(negedge sck) if (!ssel) fall_cnt <= fall_cnt + 1;

   always @(posedge sck2) if (!ssel2) begin
      r2_cnt <= r2_cnt + 1;
      m2_sh  <= {m2_sh[W2-2:0], mosi2};
   end

   // Slave-side MISO source: either loopback or a word shifted out MSB first,
   // advancing one bit per falling SCK edge of the current frame.
   bit           loop_mode = 1'b1;
   logic [W-1:0] miso_word = '0;
   int           fall_base = 0;
   int           fi;
   logic         miso_bit;

   always_comb begin
      fi       = fall_cnt - fall_base;
      miso_bit = 1'b0;
      if (fi >= 0 && fi < W) miso_bit = miso_word[W-1-fi];
   end

   assign miso = loop_mode ? mosi : miso_bit;

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ssel !== 1'b1) begin errors++; $display("FAIL reset_ssel got %b want 1", ssel); end
      checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx got %h want 0", rx_data); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      $display("reset: ssel=%b sck=%b mosi=%b ready=%b", ssel, sck, mosi, ready);
   endtask

   // One frame with random busy-time start pulses and tx_data churn.
   task automatic run_frame(input logic [W-1:0] tx, input bit lp,
                            input logic [W-1:0] mw, input string nm);
      int dcyc, rcyc, dcnt, rbase;
      logic [W-1:0] exp_rx;
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_idle_ready got %b want 1", nm, ready); end
      loop_mode = lp;
      miso_word = mw;
      rbase     = rise_cnt;
      fall_base = fall_cnt;
      tx_data   = tx;
      start     = 1'b1;
      exp_rx    = lp ? tx : mw;
      dcyc = -1; rcyc = -1; dcnt = 0;
      for (int c = 1; c <= P + 2; c++) begin
         @(negedge clk);
         if (c < P - 1) begin
            start   = ($urandom_range(0, 3) == 0);
            tx_data = $urandom;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            dcnt++;
            if (dcyc < 0) dcyc = c;
         end
         if (ready === 1'b1 && rcyc < 0) rcyc = c;
      end
      checks++; if (dcyc !== N) begin errors++; $display("FAIL %s_done_cycle got %0d want %0d", nm, dcyc, N); end
      checks++; if (dcnt !== 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", nm, dcnt); end
      checks++; if (rcyc !== P) begin errors++; $display("FAIL %s_ready_cycle got %0d want %0d", nm, rcyc, P); end
      checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL %s_rx got %h want %h", nm, rx_data, exp_rx); end
      checks++; if (rise_cnt - rbase !== W) begin errors++; $display("FAIL %s_rises got %0d want %0d", nm, rise_cnt - rbase, W); end
      checks++; if (fall_cnt - fall_base !== W) begin errors++; $display("FAIL %s_falls got %0d want %0d", nm, fall_cnt - fall_base, W); end
      checks++; if (mosi_sh !== tx) begin errors++; $display("FAIL %s_mosi_word got %h want %h", nm, mosi_sh, tx); end
      checks++; if (ssel !== 1'b1 || mosi !== 1'b0) begin errors++; $display("FAIL %s_idle_lines got ssel=%b mosi=%b want 1/0", nm, ssel, mosi); end
      $display("frame %s: tx=%h rx=%h done@%0d ready@%0d", nm, tx, rx_data, dcyc, rcyc);
   endtask

   task automatic test_back_to_back();
      int dq[$];
      int rq[$];
      int waited;
      @(negedge clk);
      loop_mode = 1'b1;
      start     = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         if (c > 0) @(negedge clk);
         tx_data = $urandom;
         if (done === 1'b1) dq.push_back(c);
         if (ready === 1'b1) rq.push_back(c);
      end
      start = 1'b0;
      checks++; if (dq.size() !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", dq.size()); end
      for (int i = 0; i < dq.size() && i < 3; i++) begin
         checks++; if (dq[i] !== N + P * i) begin errors++; $display("FAIL b2b_done_at[%0d] got %0d want %0d", i, dq[i], N + P * i); end
      end
      checks++; if (rq.size() !== 4) begin errors++; $display("FAIL b2b_ready_count got %0d want 4", rq.size()); end
      for (int i = 0; i < rq.size() && i < 4; i++) begin
         checks++; if (rq[i] !== P * i) begin errors++; $display("FAIL b2b_ready_at[%0d] got %0d want %0d", i, rq[i], P * i); end
      end
      waited = 0;
      while (ready !== 1'b1 && waited < 2 * P) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_drain got ready=%b want 1", ready); end
      $display("back_to_back: dones=%0d readies=%0d", dq.size(), rq.size());
   endtask

   task automatic test_reset_mid();
      int rbase, waited, dcnt;
      @(negedge clk);
      loop_mode = 1'b1;
      rbase     = rise_cnt;
      tx_data   = $urandom;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (rise_cnt - rbase < 13 && waited < P) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (rise_cnt - rbase !== 13) begin errors++; $display("FAIL midrst_reach_bit got %0d want 13", rise_cnt - rbase); end
      rst_n = 1'b0;
      #1;
      checks++; if (ssel !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0) begin
         errors++; $display("FAIL midrst_lines got ssel=%b sck=%b mosi=%b want 1/0/0", ssel, sck, mosi);
      end
      checks++; if (rx_data !== '0) begin errors++; $display("FAIL midrst_rx got %h want 0", rx_data); end
      dcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2 * D; c++) begin
         @(negedge clk);
         if (done === 1'b1) dcnt++;
      end
      checks++; if (dcnt !== 0) begin errors++; $display("FAIL midrst_done got %0d pulses want 0", dcnt); end
      checks++; if (ready !== 1'b1 || rx_data !== '0) begin
         errors++; $display("FAIL midrst_after got ready=%b rx=%h want 1/0", ready, rx_data);
      end
      $display("reset_mid: aborted at rise %0d, rx=%h", rise_cnt - rbase, rx_data);
   endtask

   task automatic test_small();
      int dcyc, rbase;
      @(negedge clk);
      rbase  = r2_cnt;
      tx2    = 8'h3C;
      start2 = 1'b1;
      dcyc   = -1;
      for (int c = 1; c <= N2 + D2 + 2; c++) begin
         @(negedge clk);
         start2 = 1'b0;
         tx2    = 8'($urandom);
         if (done2 === 1'b1 && dcyc < 0) dcyc = c;
      end
      checks++; if (dcyc !== N2) begin errors++; $display("FAIL small_done_cycle got %0d want %0d", dcyc, N2); end
      checks++; if (m2_sh !== 8'h3C) begin errors++; $display("FAIL small_mosi_seq got %b want 00111100", m2_sh); end
      checks++; if (rx2 !== 8'h3C) begin errors++; $display("FAIL small_rx got %h want 3c", rx2); end
      checks++; if (r2_cnt - rbase !== W2) begin errors++; $display("FAIL small_rises got %0d want %0d", r2_cnt - rbase, W2); end
      $display("small: mosi=%b rx=%h done@%0d", m2_sh, rx2, dcyc);
   endtask

   initial begin
      test_reset();
      run_frame(32'hA5C30F96, 1'b1, 32'h0, "loop_a5c3");
      run_frame(32'h12345678, 1'b0, 32'hFFFFFFFF, "miso_one");
      run_frame(32'h87654321, 1'b0, 32'h00000000, "miso_zero");
      for (int i = 0; i < 3; i++) begin
         run_frame($urandom, 1'b0, $urandom, "rand_miso");
      end
      run_frame($urandom, 1'b1, 32'h0, "rand_loop");
      test_back_to_back();
      test_reset_mid();
      run_frame($urandom, 1'b1, 32'h0, "post_reset");
      test_small();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
